clk_edge_rx: RTL and testbench
==============================

# clk_edge_rx

Receiving end of the divided clock. Samples a slow clock or strobe (such as the divider's `sclk`) in the fast `clk` domain and synchronizes it. Converts the strobe to single-cycle rise/fall enable pulses, measures its period in `clk` cycles and flags loss of the strobe. Downstream logic (servo/PWM timing, sensor sampling) runs on `clk` and uses these pulses as clock enables instead of clocking from `sclk`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count, min 2.
- `CNT_W`, default 16: width of period counter and `period` output.
- `TIMEOUT`, default 10000: `clk` cycles without a rising edge before stall; legal range 2 .. 2^CNT_W-1.
- `FILT_LEN`, default 4: glitch-filter stability length, used only with `CLK_EDGE_RX_FILT_EN`.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk_in` in 1: asynchronous slow clock/strobe input.
- `rise_pulse` out 1: one-cycle pulse per accepted rising edge.
- `fall_pulse` out 1: one-cycle pulse per accepted falling edge.
- `period` out CNT_W: last measured rise-to-rise period in `clk` cycles.
- `period_vld` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: two consecutive rises seen within TIMEOUT.
- `stalled` out 1: no rise for TIMEOUT cycles.

## Operation
- Path: `sclk_in` goes through a SYNC_STAGES flop chain, then an optional filter, then a `prev` flop. Edge detect compares the filtered level with `prev`. `rise_pulse`/`fall_pulse` are registered.
- Period counter `cnt`:
  - loads 1 in the cycle `rise_pulse` is asserted;
  - otherwise increments;
  - saturates at 2^CNT_W-1.
  - For rise pulses N cycles apart, `period` = N.
- FSM states IDLE, MEASURE, LOCKED, STALL:
  - IDLE: wait for first rise, then MEASURE. `period` is not updated.
  - MEASURE: on rise, `period`<=`cnt`, pulse `period_vld`, go to LOCKED. If `cnt`==TIMEOUT, go to STALL.
  - LOCKED: on every rise, capture `period` and pulse `period_vld`. If `cnt`==TIMEOUT, go to STALL.
  - STALL: on rise, go to MEASURE with no capture. `period` holds its last value.
- `locked` = (state==LOCKED). `stalled` = (state==STALL). Both are registered outputs of the state.
- Boundary conditions:
  - A rise in the same cycle `cnt`==TIMEOUT takes priority; no stall.
  - Rise and fall are never asserted together, because the level is a single bit.

## Timing
- Reset values:
  - all outputs 0, `period`=0;
  - sync chain, `prev` and filter state 0;
  - `cnt`=0, FSM in IDLE.
- Reset is effective immediately on `rst_n` low, including mid-lock.
- If `sclk_in` is high at reset release, one `rise_pulse` follows and is accepted as the first edge.
- Latency without filter:
  - `rise_pulse`/`fall_pulse` assert SYNC_STAGES+1 cycles after the first `clk` edge that samples the new level.
- `period_vld` is coincident with the `rise_pulse` that causes capture. `period` is valid from the same cycle and held until the next capture.
- `locked` rises one cycle after the capturing `rise_pulse`.
- `stalled` rises one cycle after `cnt` reaches TIMEOUT.
- Minimum resolvable input high/low time is 1 `clk` cycle plus synchronizer margin. Shorter pulses may be missed.

## Configuration
- `CLK_EDGE_RX_FILT_EN` defined:
  - A filter sits between the synchronizer and `prev`.
  - The filtered level changes only after the synchronized level differs from it for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN are discarded.
  - Adds FILT_LEN cycles of edge latency.
- `CLK_EDGE_RX_FILT_EN` undefined:
  - The filter is absent; the synchronized level feeds `prev` directly.
  - FILT_LEN is ignored.

## Structure
- Shared package `clk_edge_rx_pkg`: FSM state enum (IDLE, MEASURE, LOCKED, STALL) and default constants for SYNC_STAGES, CNT_W, TIMEOUT.
- One sub-module, `sync_edge_det`, holds the synchronizer chain, optional filter, `prev` flop and registered rise/fall pulses.
- The top level holds the counter, FSM and output registers.

## Test plan
Default configuration for all scenarios: SYNC_STAGES=2, CNT_W=16, TIMEOUT=100, FILT_LEN=4.
- Reset with `sclk_in`=0 for 20 cycles -> all outputs 0, state IDLE, no pulses.
- Square wave, period 20 (10 high/10 low):
  - `rise_pulse` 3 cycles after the first sampling edge;
  - `fall_pulse` every 20 cycles, offset by 10;
  - at the second rise: `period`=20, `period_vld` for 1 cycle, `locked`=1 on the next cycle.
- Locked at period 20, then `sclk_in` held low:
  - `stalled`=1 and `locked`=0 exactly 101 cycles after the last `rise_pulse`;
  - after resume, the first rise gives no `period_vld`; the second rise gives `period`=20 and `locked`=1.
- Period changes from 20 to 40 while locked -> the first rise spaced 40 captures `period`=40 and `locked` stays 1.
- `rst_n` pulled low mid-lock, asynchronously between `clk` edges:
  - outputs clear immediately and `period` reads 0;
  - after release, relock follows after two rises.
- 2-cycle high glitch on a low `sclk_in`:
  - with `CLK_EDGE_RX_FILT_EN`: no pulses;
  - without it: one `rise_pulse`, then one `fall_pulse` 2 cycles later.

Source files
------------

// File: rtl/clk_edge_rx_pkg.sv
// rtl/clk_edge_rx_pkg.sv - shared state type and default constants for clk_edge_rx
// Optional glitch filter is enabled by defining CLK_EDGE_RX_FILT_EN.
package clk_edge_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2,
      STALL   = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_TIMEOUT     = 10000;
   localparam int DEF_FILT_LEN    = 4;

endpackage

// File: rtl/clk_edge_rx_sync_edge_det.sv
// rtl/clk_edge_rx_sync_edge_det.sv - synchronizer, optional glitch filter and registered edge pulses
// Filter stage present only when CLK_EDGE_RX_FILT_EN is defined.
module sync_edge_det
   import clk_edge_rx_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_edge_det: SYNC_STAGES must be at least 2");
   end
   if (FILT_LEN < 1) begin : g_bad_filt
      $error("sync_edge_det: FILT_LEN must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic                   lvl;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef CLK_EDGE_RX_FILT_EN
   localparam int RUN_W = $clog2(FILT_LEN + 1);

   logic             filt_q;
   logic [RUN_W-1:0] run_q;

   // Level only flips once the synchronized input has disagreed for FILT_LEN cycles in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         run_q  <= '0;
      end else if (sync_lvl != filt_q) begin
         if (run_q == RUN_W'(FILT_LEN - 1)) begin
            filt_q <= sync_lvl;
            run_q  <= '0;
         end else begin
            run_q <= run_q + 1'b1;
         end
      end else begin
         run_q <= '0;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync_lvl;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= lvl;
         rise_q <= lvl & ~prev_q;
         fall_q <= ~lvl & prev_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/clk_edge_rx.sv
// rtl/clk_edge_rx.sv - slow strobe receiver: edge enables, period measurement, lock/stall tracking
// Optional glitch filter in the edge detector via CLK_EDGE_RX_FILT_EN.
module clk_edge_rx
   import clk_edge_rx_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
   output logic             stalled
);

   if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
      $error("clk_edge_rx: TIMEOUT out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic             capture;
   logic             timeout_hit;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sclk_in),
      .rise  (rise_pulse),
      .fall  (fall_pulse)
   );

   // Loading 1 on the rise makes cnt equal the rise-to-rise distance at the next rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_q <= '0;
      else if (rise_pulse)       cnt_q <= CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
   end

   assign capture     = rise_pulse && (state_q == MEASURE || state_q == LOCKED);
   assign timeout_hit = (cnt_q == TO_VAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         period_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) period_q <= cnt_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:            if (rise_pulse) state_d = MEASURE;
         MEASURE, LOCKED: begin
            if (rise_pulse)       state_d = LOCKED;
            else if (timeout_hit) state_d = STALL;
         end
         STALL:           if (rise_pulse) state_d = MEASURE;
         default:         state_d = IDLE;
      endcase
   end

   // Bypass so the new period is visible in the same cycle as period_vld.
   assign period     = capture ? cnt_q : period_q;
   assign period_vld = capture;
   assign locked     = (state_q == LOCKED);
   assign stalled    = (state_q == STALL);

endmodule

// File: tb/tb_clk_edge_rx.sv
// tb/tb_clk_edge_rx.sv - self-checking bench for clk_edge_rx with a timeline-level reference model
// Expected edge latencies include the extra filter delay when CLK_EDGE_RX_FILT_EN is defined.
module tb_clk_edge_rx;

   localparam int S  = 2;
   localparam int TO = 100;
`ifdef CLK_EDGE_RX_FILT_EN
   localparam int FL = 4;
`else
   localparam int FL = 0;
`endif

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        sclk_in = 1'b0;
   logic        rise_pulse, fall_pulse, period_vld, locked, stalled;
   logic [15:0] period;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] lv = '0;
   int rise_c[$], fall_c[$], vld_c[$], vld_p[$], lock_on_c[$], stall_on_c[$];
   logic locked_d  = 1'b0;
   logic stalled_d = 1'b0;

   typedef enum {M_IDLE, M_MEAS, M_LOCK, M_STALL} mode_t;
   mode_t mode = M_IDLE;
   mode_t nxt;
   int    last_rise = 0;
   int    since;
   int    hold_p = 0;
   logic  er, ef, ev;

   int s_edge, c_edge, d_edge, e_edge, g_edge;

   clk_edge_rx #(
      .SYNC_STAGES (S),
      .CNT_W       (16),
      .TIMEOUT     (TO),
      .FILT_LEN    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_in    (sclk_in),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .period     (period),
      .period_vld (period_vld),
      .locked     (locked),
      .stalled    (stalled)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // lv[k] is the input level sampled k edges ago
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lv <= '0;
      else        lv <= {lv[6:0], sclk_in};
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int first_ge(input int q[$], input int c);
      foreach (q[i]) if (q[i] >= c) return q[i];
      return -1;
   endfunction

   function automatic int count_in(input int q[$], input int lo, input int hi);
      int n = 0;
      foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
      return n;
   endfunction

   function automatic int vld_period_at(input int c);
      foreach (vld_c[i]) if (vld_c[i] == c) return vld_p[i];
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rise_pulse) rise_c.push_back(cyc);
      if (fall_pulse) fall_c.push_back(cyc);
      if (period_vld) begin
         vld_c.push_back(cyc);
         vld_p.push_back(int'(period));
      end
      if (locked && !locked_d)   lock_on_c.push_back(cyc);
      if (stalled && !stalled_d) stall_on_c.push_back(cyc);
      locked_d  = locked;
      stalled_d = stalled;
`ifndef CLK_EDGE_RX_FILT_EN
      if (!rst_n) begin
         er = 1'b0; ef = 1'b0; ev = 1'b0;
         hold_p = 0;
         mode = M_IDLE;
         nxt  = M_IDLE;
      end else begin
         er    = lv[S] & ~lv[S+1];
         ef    = ~lv[S] & lv[S+1];
         ev    = 1'b0;
         nxt   = mode;
         since = cyc - last_rise;
         if (er) begin
            if (mode == M_MEAS || mode == M_LOCK) begin
               ev     = 1'b1;
               hold_p = (since > 65535) ? 65535 : since;
               nxt    = M_LOCK;
            end else begin
               nxt = M_MEAS;
            end
            last_rise = cyc;
         end else if ((mode == M_MEAS || mode == M_LOCK) && since == TO) begin
            nxt = M_STALL;
         end
      end
      chk("rise_pulse", rise_pulse, er);
      chk("fall_pulse", fall_pulse, ef);
      chk("period_vld", period_vld, ev);
      chk("period", period, hold_p);
      chk("locked", locked, mode == M_LOCK);
      chk("stalled", stalled, mode == M_STALL);
      mode = nxt;
`endif
   end

   task automatic hold_lvl(input logic l, input int n);
      sclk_in = l;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic square(input int hi, input int lo, input int n);
      repeat (n) begin
         hold_lvl(1'b1, hi);
         hold_lvl(1'b0, lo);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      sclk_in = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("reset_rise", rise_pulse, 0);
      chk("reset_fall", fall_pulse, 0);
      chk("reset_vld", period_vld, 0);
      chk("reset_period", period, 0);
      chk("reset_locked", locked, 0);
      chk("reset_stalled", stalled, 0);
      rst_n = 1'b1;
      hold_lvl(1'b0, 5);

      // square wave, period 20
      s_edge = cyc + 1;
      square(10, 10, 4);
      chk("rise_latency", first_ge(rise_c, s_edge) - s_edge + 1, 3 + FL);
      chk("fall_offset", first_ge(fall_c, s_edge) - s_edge, 12 + FL);
      chk("second_rise", first_ge(rise_c, s_edge + 3 + FL) - s_edge, 22 + FL);
      chk("first_vld", first_ge(vld_c, s_edge) - s_edge, 22 + FL);
      chk("first_period", vld_period_at(s_edge + 22 + FL), 20);
      chk("vld_one_cycle", first_ge(vld_c, s_edge + 23 + FL) - s_edge, 42 + FL);
      chk("locked_delay", first_ge(lock_on_c, s_edge) - s_edge, 23 + FL);

      // strobe lost, then resumed
      hold_lvl(1'b0, 150);
      chk("stall_delay", first_ge(stall_on_c, s_edge) - (s_edge + 62 + FL), 101);
      chk("locked_in_stall", locked, 0);
      chk("stalled_held", stalled, 1);
      c_edge = cyc + 1;
      square(10, 10, 3);
      chk("resume_first_no_vld", count_in(vld_c, c_edge, c_edge + 21 + FL), 0);
      chk("resume_period", vld_period_at(c_edge + 22 + FL), 20);
      chk("resume_lock", first_ge(lock_on_c, c_edge) - c_edge, 23 + FL);

      // period change 20 -> 40 while locked
      d_edge = cyc + 1;
      square(20, 20, 3);
      chk("period_before_change", vld_period_at(d_edge + 2 + FL), 20);
      chk("period_after_change", vld_period_at(d_edge + 42 + FL), 40);
      chk("lock_drops_40", count_in(lock_on_c, d_edge, cyc), 0);
      chk("locked_after_40", locked, 1);

      // asynchronous reset mid-lock
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rise", rise_pulse, 0);
      chk("async_rst_vld", period_vld, 0);
      chk("async_rst_period", period, 0);
      chk("async_rst_locked", locked, 0);
      chk("async_rst_stalled", stalled, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      e_edge = cyc + 1;
      square(10, 10, 3);
      chk("rst_first_no_vld", count_in(vld_c, e_edge, e_edge + 21 + FL), 0);
      chk("rst_relock_period", vld_period_at(e_edge + 22 + FL), 20);
      chk("rst_relock", first_ge(lock_on_c, e_edge) - e_edge, 23 + FL);

      // 2-cycle glitch on a low input
      hold_lvl(1'b0, 30);
      g_edge = cyc + 1;
      hold_lvl(1'b1, 2);
      hold_lvl(1'b0, 30);
`ifdef CLK_EDGE_RX_FILT_EN
      chk("glitch_rises", count_in(rise_c, g_edge, g_edge + 29), 0);
      chk("glitch_falls", count_in(fall_c, g_edge, g_edge + 29), 0);
`else
      chk("glitch_rises", count_in(rise_c, g_edge, g_edge + 29), 1);
      chk("glitch_rise_at", first_ge(rise_c, g_edge) - g_edge, 2);
      chk("glitch_fall_at", first_ge(fall_c, g_edge) - g_edge, 4);
`endif
      hold_lvl(1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
